// File: rtl/button_conditioner.sv
// Synchronises, debounces and one-hot-qualifies 4 product and 3 money push buttons; outputs are registered.
// Latency DB_CYCLES+3 edges from raw change to output change; no flow control, outputs are plain levels.
module button_conditioner #(
  parameter int DB_CYCLES = 8,
  parameter int CNT_W     = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] pb_p,
  input  logic [2:0] pb_d,
  output logic [3:0] P,
  output logic [2:0] D,
  output logic       err_p,
  output logic       err_d
);

  localparam int NB = 7;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    BLOCK = 2'd2
  } state_t;

  logic [NB-1:0]    raw;
  logic [NB-1:0]    s1;
  logic [NB-1:0]    s2;
  logic [NB-1:0]    st;
  logic [CNT_W-1:0] cnt [NB];

  assign raw = {pb_d, pb_p};

  // Any cycle where s2 agrees with st restarts the count, so short glitches never land.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      st <= '0;
      for (int i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < NB; i++) begin
        if (s2[i] == st[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          st[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_grp
    localparam int W   = (g == 0) ? 4 : 3;
    localparam int LSB = (g == 0) ? 0 : 4;

    state_t         state;
    state_t         state_n;
    logic [W-1:0]   s;
    logic [W-1:0]   code;
    logic [W-1:0]   code_n;
    logic [W-1:0]   out_q;
    logic [W-1:0]   out_n;
    logic           err_q;
    logic           err_n;
    logic           one_hot;

    assign s       = st[LSB +: W];
    assign one_hot = (s != '0) && ((s & (s - W'(1))) == '0);

    always_ff @(posedge clock) begin
      if (reset) begin
        state <= IDLE;
        code  <= '0;
        out_q <= '0;
        err_q <= 1'b0;
      end else begin
        state <= state_n;
        code  <= code_n;
        out_q <= out_n;
        err_q <= err_n;
      end
    end

    always_comb begin
      state_n = state;
      code_n  = code;
      out_n   = out_q;
      err_n   = err_q;
      case (state)
        IDLE: begin
          if (one_hot) begin
            state_n = VALID;
            code_n  = s;
            out_n   = s;
          end else if (s != '0) begin
            state_n = BLOCK;
            err_n   = 1'b1;
          end
        end
        VALID: begin
          if (s == '0) begin
            state_n = IDLE;
            out_n   = '0;
          end else if (s != code) begin
            state_n = BLOCK;
            out_n   = '0;
            err_n   = 1'b1;
          end
        end
        BLOCK: begin
          // Only a full release unblocks; a leftover single bit is not a fresh press.
          if (s == '0) begin
            state_n = IDLE;
            err_n   = 1'b0;
          end
        end
        default: begin
          state_n = IDLE;
          out_n   = '0;
          err_n   = 1'b0;
        end
      endcase
    end

    if (g == 0) begin : g_out_p
      assign P     = out_q;
      assign err_p = err_q;
    end else begin : g_out_d
      assign D     = out_q;
      assign err_d = err_q;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: DB_CYCLES=8 instance plus a DB_CYCLES=1 instance.
module tb_button_conditioner;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] pb_p  = 4'b0;
  logic [2:0] pb_d  = 3'b0;
  logic [3:0] P;
  logic [2:0] D;
  logic       err_p;
  logic       err_d;

  logic [3:0] pb_p_f = 4'b0;
  logic [2:0] pb_d_f = 3'b0;
  logic [3:0] P_f;
  logic [2:0] D_f;
  logic       err_p_f;
  logic       err_d_f;

  int checks = 0;
  int passed = 0;

  always #5 clock = ~clock;

  button_conditioner #(.DB_CYCLES(8), .CNT_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .pb_p  (pb_p),
    .pb_d  (pb_d),
    .P     (P),
    .D     (D),
    .err_p (err_p),
    .err_d (err_d)
  );

  button_conditioner #(.DB_CYCLES(1), .CNT_W(1)) dut_fast (
    .clock (clock),
    .reset (reset),
    .pb_p  (pb_p_f),
    .pb_d  (pb_d_f),
    .P     (P_f),
    .D     (D_f),
    .err_p (err_p_f),
    .err_d (err_d_f)
  );

  // Advance one rising edge, then settle so inputs and outputs are away from the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    step();
    check("rst_P", P, 4'b0000);
    check("rst_D", {1'b0, D}, 4'b0000);
    check("rst_err_p", {3'b0, err_p}, 4'b0000);
    check("rst_err_d", {3'b0, err_d}, 4'b0000);
    step();
    step();
    reset = 1'b0;

    // 1: single product press/release, DB_CYCLES+3 edges each way
    pb_p = 4'b0100;
    for (int i = 1; i <= 10; i++) begin
      step();
      check("t1_press_wait", P, 4'b0000);
    end
    step();
    check("t1_press_edge11", P, 4'b0100);
    check("t1_err_p", {3'b0, err_p}, 4'b0000);
    for (int i = 0; i < 9; i++) begin
      step();
      check("t1_hold", P, 4'b0100);
    end
    pb_p = 4'b0000;
    for (int i = 1; i <= 10; i++) begin
      step();
      check("t1_release_wait", P, 4'b0100);
    end
    step();
    check("t1_release_edge11", P, 4'b0000);

    // 2: bouncing money input never accepted
    for (int i = 0; i < 40; i++) begin
      pb_d = ((i / 3) % 2 == 0) ? 3'b010 : 3'b000;
      step();
      check("t2_bounce_D", {1'b0, D}, 4'b0000);
      check("t2_bounce_err", {3'b0, err_d}, 4'b0000);
    end
    pb_d = 3'b000;
    for (int i = 0; i < 12; i++) begin
      step();
      check("t2_settle_D", {1'b0, D}, 4'b0000);
    end

    // 3: multi-press blocks, partial release stays blocked
    pb_p = 4'b0001;
    for (int i = 0; i < 11; i++) step();
    check("t3_first_valid", P, 4'b0001);
    pb_p = 4'b1001;
    for (int i = 0; i < 10; i++) step();
    check("t3_pre_block_P", P, 4'b0001);
    check("t3_pre_block_err", {3'b0, err_p}, 4'b0000);
    step();
    check("t3_block_P", P, 4'b0000);
    check("t3_block_err", {3'b0, err_p}, 4'b0001);
    pb_p = 4'b0001;
    for (int i = 0; i < 15; i++) begin
      step();
      check("t3_partial_P", P, 4'b0000);
      check("t3_partial_err", {3'b0, err_p}, 4'b0001);
    end
    pb_p = 4'b0000;
    for (int i = 0; i < 10; i++) step();
    check("t3_unblock_wait_err", {3'b0, err_p}, 4'b0001);
    step();
    check("t3_unblock_err", {3'b0, err_p}, 4'b0000);
    check("t3_unblock_P", P, 4'b0000);
    for (int i = 0; i < 4; i++) step();

    // 4: independent groups pressed in the same cycle
    pb_p = 4'b0010;
    pb_d = 3'b100;
    for (int i = 0; i < 10; i++) step();
    check("t4_wait_P", P, 4'b0000);
    check("t4_wait_D", {1'b0, D}, 4'b0000);
    step();
    check("t4_P", P, 4'b0010);
    check("t4_D", {1'b0, D}, 4'b0100);
    check("t4_err_p", {3'b0, err_p}, 4'b0000);
    check("t4_err_d", {3'b0, err_d}, 4'b0000);
    pb_p = 4'b0000;
    pb_d = 3'b000;
    for (int i = 0; i < 12; i++) step();
    check("t4_release_P", P, 4'b0000);
    check("t4_release_D", {1'b0, D}, 4'b0000);

    // 5: reset mid-press, button re-debounced afterwards
    pb_d = 3'b001;
    for (int i = 0; i < 11; i++) step();
    check("t5_valid", {1'b0, D}, 4'b0001);
    reset = 1'b1;
    step();
    check("t5_reset_D", {1'b0, D}, 4'b0000);
    step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("t5_post_wait", {1'b0, D}, 4'b0000);
    step();
    check("t5_post_D", {1'b0, D}, 4'b0001);
    pb_d = 3'b000;
    for (int i = 0; i < 12; i++) step();
    check("t5_release_D", {1'b0, D}, 4'b0000);

    // 6: DB_CYCLES=1 accepts a single-cycle pulse
    pb_p_f = 4'b0001;
    step();
    pb_p_f = 4'b0000;
    check("t6_edge1", P_f, 4'b0000);
    step();
    check("t6_edge2", P_f, 4'b0000);
    step();
    check("t6_edge3", P_f, 4'b0000);
    step();
    check("t6_edge4", P_f, 4'b0001);
    step();
    check("t6_edge5", P_f, 4'b0000);
    check("t6_err", {3'b0, err_p_f}, 4'b0000);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
